// File: rtl/pipelined_mux_nx1.sv
// ----------------------------------------------------------------------------
// pipelined_mux_nx1
//
// Purpose:
//    N-input, WIDTH-bit selector followed by a STAGES-deep output pipeline.
//    Each stage carries {data, valid, sel}. The stall input freezes the whole
//    pipe. The flush input zeroes every stage and takes priority over stall.
//    A sticky flag records any valid operation whose select was out of range.
//
// Ports:
//    clk        rising-edge clock
//    rst        asynchronous, active-high reset
//    in_data    NUM_IN*WIDTH flattened inputs, input i at [i*WIDTH +: WIDTH]
//    sel        SEL_W-bit input index
//    in_valid   current sel/in_data is a real operation
//    stall      hold all stages
//    flush      kill all in-flight entries (wins over stall)
//    out_data   data from the last stage
//    out_valid  valid bit from the last stage
//    out_sel    select value that produced out_data
//    sel_err    sticky out-of-range select flag (cleared only by rst)
// ----------------------------------------------------------------------------
module pipelined_mux_nx1 #(
   parameter int  WIDTH  = 32,
   parameter int  NUM_IN = 4,
   parameter int  STAGES = 1,
   localparam int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_IN*WIDTH-1:0]   in_data,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      in_valid,
   input  logic                      stall,
   input  logic                      flush,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   output logic [SEL_W-1:0]          out_sel,
   output logic                      sel_err
);

   // Reject illegal parameterisations at elaboration time.
   if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
      $error("pipelined_mux_nx1: NUM_IN must be in 2..16");
   end
   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("pipelined_mux_nx1: STAGES must be in 1..4");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("pipelined_mux_nx1: WIDTH must be at least 1");
   end

   logic                  sel_in_range_s;
   logic [WIDTH-1:0]      pick_data_s;
   logic                  pick_valid_s;
   logic                  shift_s;

   // Stage k of the pipe lives at index k-1; index STAGES-1 drives the outputs.
   logic [WIDTH-1:0]      data_q  [STAGES];
   logic [WIDTH-1:0]      data_d  [STAGES];
   logic                  valid_q [STAGES];
   logic                  valid_d [STAGES];
   logic [SEL_W-1:0]      sel_q   [STAGES];
   logic [SEL_W-1:0]      sel_d   [STAGES];
   logic                  sel_err_q;
   logic                  sel_err_d;

   // Stage-0 combinational select; out-of-range selects yield a zero bubble.
   always_comb begin
      // SEL_W is at most 4, so a 5-bit compare covers NUM_IN = 16 exactly.
      sel_in_range_s = (5'(sel) < 5'(NUM_IN));
      if (sel_in_range_s) begin
         pick_data_s  = in_data[int'(sel)*WIDTH +: WIDTH];
         pick_valid_s = in_valid;
      end else begin
         pick_data_s  = '0;
         pick_valid_s = 1'b0;
      end
   end

   // Next-state for every stage and the sticky error flag: flush > stall > shift.
   always_comb begin
      shift_s   = !flush && !stall;
      sel_err_d = sel_err_q;
      for (int k = 0; k < STAGES; k++) begin
         data_d[k]  = data_q[k];
         valid_d[k] = valid_q[k];
         sel_d[k]   = sel_q[k];
      end
      if (flush) begin
         for (int k = 0; k < STAGES; k++) begin
            data_d[k]  = '0;
            valid_d[k] = 1'b0;
            sel_d[k]   = '0;
         end
      end else if (stall) begin
         // Every stage keeps the value loaded by the defaults above.
         sel_err_d = sel_err_q;
      end else begin
         data_d[0]  = pick_data_s;
         valid_d[0] = pick_valid_s;
         sel_d[0]   = sel;
         for (int k = 1; k < STAGES; k++) begin
            data_d[k]  = data_q[k-1];
            valid_d[k] = valid_q[k-1];
            sel_d[k]   = sel_q[k-1];
         end
      end
      // Only a real (valid) operation that actually shifts in can trip the flag.
      if (shift_s && in_valid && !sel_in_range_s) begin
         sel_err_d = 1'b1;
      end else begin
         sel_err_d = sel_err_d;
      end
   end

   // Pipeline and error-flag registers, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            data_q[k]  <= '0;
            valid_q[k] <= 1'b0;
            sel_q[k]   <= '0;
         end
         sel_err_q <= 1'b0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            data_q[k]  <= data_d[k];
            valid_q[k] <= valid_d[k];
            sel_q[k]   <= sel_d[k];
         end
         sel_err_q <= sel_err_d;
      end
   end

   assign out_data  = data_q[STAGES-1];
   assign out_valid = valid_q[STAGES-1];
   assign out_sel   = sel_q[STAGES-1];
   assign sel_err   = sel_err_q;

endmodule
